// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one single-ported memory between fetch and load/store
// Ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   if_req/if_addr -> if_gnt             fetch read request and same-cycle accept
//   if_rvalid/if_rdata                   fetch read response
//   d_req/d_we/d_addr/d_wdata/d_be       data request (read or byte-masked write)
//   d_gnt, d_rvalid/d_rdata              data accept and read response
//   mem_en/we/be/addr/wdata, mem_rdata   memory macro side, read data MEM_LATENCY cycles after mem_en
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);
    // last_d: 1 when the data port owned the most recent grant
    logic                   last_d;
    // read-tracking pipeline: valid bit and owner (1 = data) per stage
    logic [MEM_LATENCY-1:0] pipe_v;
    logic [MEM_LATENCY-1:0] pipe_d;
    always_comb begin
        if_gnt    = rst_n & if_req & (~d_req | last_d);
        d_gnt     = rst_n & d_req & (~if_req | ~last_d);
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_be    = d_gnt ? d_be : '1;
        mem_addr  = d_gnt ? d_addr : if_addr;
        mem_wdata = d_gnt ? d_wdata : '0;
        // the last stage is the read whose data is on mem_rdata now
        if_rvalid = rst_n & pipe_v[MEM_LATENCY-1] & ~pipe_d[MEM_LATENCY-1];
        d_rvalid  = rst_n & pipe_v[MEM_LATENCY-1] & pipe_d[MEM_LATENCY-1];
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_d <= 1'b1;
            pipe_v <= '0;
            pipe_d <= '0;
        end else begin
            if (mem_en)
                last_d <= d_gnt;
            pipe_v[0] <= if_gnt | (d_gnt & ~d_we);
            pipe_d[0] <= d_gnt;
            for (int i = MEM_LATENCY - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus randomized traffic against a queue-based reference model
module tb_mem_port_arbiter;
    localparam int LAT = 2;

    typedef struct {
        logic        rn, ir;
        logic [31:0] ia;
        logic        dr, dwe;
        logic [31:0] da, dwd;
        logic [3:0]  dbe;
        logic        ig, dg, irv, drv;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  d_be = 0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // memory macro model: byte-masked writes, reads returned LAT cycles after mem_en
    logic [31:0] mem [4096];
    logic [31:0] rd_q [LAT];
    assign mem_rdata = rd_q[LAT-1];
    always @(posedge clk) begin
        if (mem_en && mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        rd_q[0] <= (mem_en && !mem_we) ? mem[mem_addr[13:2]] : $urandom;
        for (int i = 1; i < LAT; i++) rd_q[i] <= rd_q[i-1];
    end

    int   errors = 0, checks = 0, cyc = 0;
    bit   last_d = 1;
    rsp_t q[$];
    logic eg_i, eg_d;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // one clock cycle: inputs already driven, check at negedge, advance model, step past posedge
    task automatic cycle(input vec_t v, input bit use_exp);
        logic irv, drv;
        logic [31:0] rd;
        @(negedge clk);
        eg_i = rst_n && if_req && (!d_req || last_d);
        eg_d = rst_n && d_req && (!if_req || !last_d);
        irv = 0; drv = 0; rd = 0;
        if (rst_n && q.size() > 0 && q[0].due == cyc) begin
            rd = q[0].data;
            if (q[0].port) drv = 1; else irv = 1;
            void'(q.pop_front());
        end
        chk("if_gnt", 32'(if_gnt), 32'(eg_i));
        chk("d_gnt", 32'(d_gnt), 32'(eg_d));
        chk("mem_en", 32'(mem_en), 32'(eg_i | eg_d));
        chk("mem_we", 32'(mem_we), 32'(eg_d & d_we));
        if (eg_i) begin
            chk("mem_addr_if", mem_addr, if_addr);
            chk("mem_be_if", 32'(mem_be), 32'hF);
            chk("mem_wdata_if", mem_wdata, 0);
        end
        if (eg_d) begin
            chk("mem_addr_d", mem_addr, d_addr);
            chk("mem_be_d", 32'(mem_be), 32'(d_be));
            if (d_we) chk("mem_wdata_d", mem_wdata, d_wdata);
        end
        chk("if_rvalid", 32'(if_rvalid), 32'(irv));
        chk("d_rvalid", 32'(d_rvalid), 32'(drv));
        if (irv) begin
            chk("if_rdata", if_rdata, rd);
            chk("d_rdata_idle", d_rdata, 0);
        end
        if (drv) begin
            chk("d_rdata", d_rdata, rd);
            chk("if_rdata_idle", if_rdata, 0);
        end
        if (use_exp) begin
            chk("vec_if_gnt", 32'(if_gnt), 32'(v.ig));
            chk("vec_d_gnt", 32'(d_gnt), 32'(v.dg));
            chk("vec_if_rvalid", 32'(if_rvalid), 32'(v.irv));
            chk("vec_d_rvalid", 32'(d_rvalid), 32'(v.drv));
            if (v.irv) chk("vec_if_rdata", if_rdata, v.rd);
            if (v.drv) chk("vec_d_rdata", d_rdata, v.rd);
        end
        if (!rst_n) begin
            q.delete();
            last_d = 1;
        end else begin
            if (eg_i) begin
                q.push_back('{cyc + LAT, 1'b0, mem[if_addr[13:2]]});
                last_d = 0;
            end
            if (eg_d) begin
                if (!d_we) q.push_back('{cyc + LAT, 1'b1, mem[d_addr[13:2]]});
                last_d = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic vec_t v(logic rn, logic ir, logic [31:0] ia, logic dr, logic dwe,
                               logic [31:0] da, logic [31:0] dwd, logic [3:0] dbe,
                               logic ig, logic dg, logic irv, logic drv, logic [31:0] rd);
        return '{rn, ir, ia, dr, dwe, da, dwd, dbe, ig, dg, irv, drv, rd};
    endfunction

    task automatic apply(input vec_t x);
        rst_n = x.rn; if_req = x.ir; if_addr = x.ia;
        d_req = x.dr; d_we = x.dwe; d_addr = x.da; d_wdata = x.dwd; d_be = x.dbe;
    endtask

    vec_t tbl[29];
    vec_t none;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = {16'hC0DE, 16'(i)};
        mem[4] = 32'h00500093;
        tbl[0]  = v(0, 1, 32'h10, 1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0);
        tbl[1]  = tbl[0];
        tbl[2]  = v(1, 1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[3]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h00500093);
        tbl[5]  = v(1, 0, 0, 1, 1, 32'h2004, 32'hDEADBEEF, 4'b0011, 0, 1, 0, 0, 0);
        tbl[6]  = tbl[3];
        tbl[7]  = tbl[3];
        tbl[8]  = v(0, 1, 0, 1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0);
        tbl[9]  = v(1, 1, 32'h0, 1, 0, 32'h100, 0, 4'hF, 1, 0, 0, 0, 0);
        tbl[10] = v(1, 1, 32'h4, 1, 0, 32'h100, 0, 4'hF, 0, 1, 0, 0, 0);
        tbl[11] = v(1, 1, 32'h4, 1, 0, 32'h104, 0, 4'hF, 1, 0, 1, 0, 32'hC0DE0000);
        tbl[12] = v(1, 1, 32'h8, 1, 0, 32'h104, 0, 4'hF, 0, 1, 0, 1, 32'hC0DE0040);
        tbl[13] = v(1, 1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'hC0DE0001);
        tbl[14] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC0DE0041);
        tbl[15] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hC0DE0002);
        tbl[16] = v(1, 1, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[17] = v(1, 1, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[18] = v(1, 1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'hC0DE0000);
        tbl[19] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hC0DE0001);
        tbl[20] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hC0DE0002);
        tbl[21] = v(1, 1, 32'hC, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[22] = v(0, 1, 32'h10, 1, 0, 32'h100, 0, 4'hF, 0, 0, 0, 0, 0);
        tbl[23] = tbl[3];
        tbl[24] = tbl[3];
        tbl[25] = v(1, 0, 0, 1, 1, 32'h200, 32'h12345678, 4'hF, 0, 1, 0, 0, 0);
        tbl[26] = v(1, 1, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[27] = tbl[3];
        tbl[28] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h12345678);
        none = tbl[3];
        @(posedge clk);
        #1;
        for (int k = 0; k < 29; k++) begin
            apply(tbl[k]);
            cycle(tbl[k], 1);
        end
        begin
            bit ipend = 0, dpend = 0;
            for (int n = 0; n < 800; n++) begin
                rst_n = ($urandom_range(0, 59) != 0);
                if (!ipend) begin
                    if_req = ($urandom_range(0, 2) != 0);
                    if_addr = 32'($urandom_range(0, 4095)) << 2;
                    ipend = if_req;
                end
                if (!dpend) begin
                    d_req = ($urandom_range(0, 2) != 0);
                    d_we = $urandom_range(0, 1) != 0;
                    d_addr = 32'($urandom_range(0, 4095)) << 2;
                    d_wdata = $urandom;
                    d_be = 4'($urandom);
                    dpend = d_req;
                end
                cycle(none, 0);
                if (eg_i) ipend = 0;
                if (eg_d) dpend = 0;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the CPU instruction-fetch port and the load/store data port.
- Grants at most one access per cycle with round-robin arbitration.
- Tracks in-flight reads through a latency pipeline and routes read data back to the requester that issued it.
- Sits between the core (fetch and LSU) and the memory macro; replaces the separate instruction and data memory instances once the core moves to a unified memory.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports; must be a multiple of 8.
- MEM_LATENCY, 1, cycles from mem_en assertion to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request
- d_we  in  1  data request is a write
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_be  in  DATA_WIDTH/8  byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid (reads only)
- d_rdata  out  DATA_WIDTH  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en

Behaviour:
- Reset: synchronous, active-low, sampled at posedge clk.
  - While rst_n=0: if_gnt, d_gnt, mem_en, if_rvalid and d_rvalid are all 0, including their combinational paths.
  - The in-flight pipeline is cleared and last_owner is set to DATA.
- Request rules:
  - A requester holds req and all request fields stable until it sees gnt.
  - gnt is combinational in the same cycle as req; the access issues that cycle.
  - The requester may drop req or present a new request in the cycle after gnt.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port that is not last_owner.
  - last_owner updates on every grant.
  - Result: after reset, the first tie goes to fetch; sustained contention strictly alternates fetch/data.
- Memory drive:
  - Granted fetch: mem_en=1, mem_we=0, mem_be=all ones, mem_addr=if_addr, mem_wdata=0.
  - Granted data: mem_en=1, mem_we=d_we, mem_be=d_be, mem_addr=d_addr, mem_wdata=d_wdata.
  - No grant: mem_en=0, mem_we=0; other mem_* outputs are don't-care.
- Response pipeline:
  - Shift register of depth MEM_LATENCY holding {valid, owner}.
  - An entry is pushed on every granted read; writes push nothing.
  - When an entry exits the pipeline, the owner's rvalid pulses for 1 cycle and that port's rdata equals mem_rdata.
  - The non-owning port's rdata is 0.
  - Writes produce no rvalid.
- Throughput: one grant per cycle; back-to-back reads are fully pipelined with no bubbles.
  - With MEM_LATENCY=2, grants at cycles t and t+1 produce rvalids at t+2 and t+3, in issue order.
- Simultaneous events:
  - A grant and an rvalid to the same port in the same cycle are both legal.
  - The two are independent.
- Reset mid-operation: all in-flight reads are discarded; no rvalid is emitted for them after reset deasserts.
- No back-pressure on responses: requesters always accept rvalid.

Test Plan:
- Fetch read alone, MEM_LATENCY=1: if_req=1, if_addr=0x10 at cycle 0 -> if_gnt=1, mem_en=1, mem_addr=0x10, mem_we=0 at cycle 0; memory returns 0x00500093 -> if_rvalid=1, if_rdata=0x00500093 at cycle 1; d_rvalid=0.
- Data write: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=4'b0011 -> d_gnt=1, mem_we=1, mem_be=4'b0011, mem_wdata=0xDEADBEEF same cycle; no d_rvalid ever.
- Contention right after reset: both ports request reads for 4 cycles -> grant order fetch, data, fetch, data; rvalids arrive MEM_LATENCY cycles later in the same order with matching data.
- Pipelining, MEM_LATENCY=3: fetch reads issued at cycles 0, 1, 2 to 0x0, 0x4, 0x8 -> if_rvalid at cycles 3, 4, 5 with data in order.
- Reset mid-flight, MEM_LATENCY=2: read granted at cycle 0, rst_n=0 at cycle 1 -> no rvalid at cycle 2 or after; all gnt outputs and mem_en=0 while in reset.
- Mixed traffic: data write at cycle 0, fetch read at cycle 1 -> mem_we=1 then 0; only if_rvalid pulses, at cycle 1+MEM_LATENCY.
